// File: rtl/mdr_fetch_ctrl_pkg.sv
// ============================================================================
// Module      : mdr_ctrl_pkg
// Description : Shared types and constants for the MDR fetch controller.
//               Holds the FSM state encoding, default widths, and the MDR
//               byte width that the MDR itself also uses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdr_ctrl_pkg;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_BYTES_PER_WORD = 2;
  localparam int DEF_TIMEOUT        = 15;
  localparam int MDR_BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Counter width that still works for a single-entry range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdr_fetch_ctrl_if.sv
// ============================================================================
// Module      : mdr_fetch_ctrl_if
// Description : Bundles the control-unit request, memory port and MDR strobes
//               of the fetch controller. The slave modport is the controller,
//               the master modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdr_fetch_ctrl_if
  import mdr_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              mem_ack;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              mdr_shift;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, start_addr, mem_ack,
    input  mem_re, mem_addr, mdr_shift, busy, done, err
  );

  modport slave (
    input  start, start_addr, mem_ack,
    output mem_re, mem_addr, mdr_shift, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/mdr_fetch_ctrl_wait_cnt.sv
// ============================================================================
// Module      : mdr_wait_cnt
// Description : Clear/enable wait counter with a terminal flag. The flag is
//               high while the count equals LIMIT-1, so the LIMIT-th enabled
//               cycle is the one that sees it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_wait_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles; clear has priority so every wait period starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/mdr_fetch_ctrl.sv
// ============================================================================
// Module      : mdr_fetch_ctrl
// Description : Sequences the MDR during a multi-byte fetch: one memory read
//               per byte (mem_re doubles as the MDR capture strobe), a single
//               shift strobe between bytes, then a one-cycle done pulse.
//               Optional macro MDR_FETCH_TIMEOUT_EN adds a per-byte ack
//               timeout that aborts through an ERR state with a sticky err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_fetch_ctrl
  import mdr_ctrl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mdr_fetch_ctrl_if.slave      bus
);

  localparam int              CNT_W     = cnt_w(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_byte_cnt;

  logic w_accept;
  logic w_ack_req;
  logic w_last;
  logic w_timeout;
  logic w_mem_re;
  logic w_shift;
  logic w_busy;
  logic w_done;

  // Start is only honoured in IDLE; ack only counts while a read is requested.
  assign w_accept  = (r_state == ST_IDLE) && bus.start;
  assign w_ack_req = (r_state == ST_REQ) && bus.mem_ack;
  assign w_last    = (r_byte_cnt == LAST_BYTE);

`ifdef MDR_FETCH_TIMEOUT_EN
  logic w_tc;
  logic r_err_sticky;

  // Held in clear outside REQ so each byte gets a fresh wait budget.
  mdr_wait_cnt #(
    .LIMIT (TIMEOUT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state != ST_REQ),
    .i_en  ((r_state == ST_REQ) && !bus.mem_ack),
    .o_tc  (w_tc)
  );

  assign w_timeout = w_tc;

  // Abort flag stays up after ERR until the next fetch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept) begin
      r_err_sticky <= 1'b0;
    end else if (r_state == ST_ERR) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign bus.err = (r_state == ST_ERR) || r_err_sticky;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign bus.err          = 1'b0;
  assign w_unused_timeout = ^32'(TIMEOUT);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte address and byte counter: load on accept, advance on each captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      r_addr     <= bus.start_addr;
      r_byte_cnt <= '0;
    end else if (w_ack_req) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (!w_last) begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and Moore output decode; ack beats a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_re    = 1'b0;
    w_shift     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_mem_re = 1'b1;
        if (bus.mem_ack) begin
          w_state_nxt = w_last ? ST_DONE : ST_SHIFT;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_SHIFT: begin
        w_shift     = 1'b1;
        w_state_nxt = ST_REQ;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_re    = w_mem_re;
  assign bus.mem_addr  = r_addr;
  assign bus.mdr_shift = w_shift;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

`default_nettype wire
